// File: rtl/ring_counter_decoder_if.sv
// Signal bundle between a ring-code source (master) and the ring_counter_decoder (slave).
// The source drives the sample and controls; the decoder returns index, lock and error status.
interface ring_counter_decoder_if #(
  parameter int WIDTH = 4,
  parameter int REV_W = 16,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
  logic             en_i;
  logic [WIDTH-1:0] ring_in_i;
  logic             clr_err_i;
  logic [IW-1:0]    idx_o;
  logic             idx_valid_o;
  logic             locked_o;
  logic             err_pulse_o;
  logic             err_sticky_o;
  logic [REV_W-1:0] rev_cnt_o;

  modport master (
    output en_i, ring_in_i, clr_err_i,
    input  idx_o, idx_valid_o, locked_o, err_pulse_o, err_sticky_o, rev_cnt_o
  );

  modport slave (
    input  en_i, ring_in_i, clr_err_i,
    output idx_o, idx_valid_o, locked_o, err_pulse_o, err_sticky_o, rev_cnt_o
  );
endinterface

// File: rtl/ring_counter_decoder.sv
// One-hot ring code monitor: decodes the hot-bit index, locks onto a legal rotation,
// counts revolutions while locked and flags sequence violations.
module ring_counter_decoder #(
  parameter int WIDTH    = 4,
  parameter int DIR      = 0,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 16,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int GW = $clog2(LOCK_CNT + 1)
) (
  input logic clk,
  input logic rst_n,
  ring_counter_decoder_if.slave bus
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;

  logic [WIDTH-1:0] ring;
  logic [WIDTH-1:0] prev_rot;
  logic [IW-1:0]    hot_idx;
  logic             sample_valid;
  logic             legal_step;
  logic [GW-1:0]    good_inc;

  assign ring = bus.ring_in_i;

  // Expected successor of the previous sample for the configured rotation direction.
  generate
    if (DIR == 0) begin : g_rot_right
      assign prev_rot = {prev_q[0], prev_q[WIDTH-1:1]};
    end else begin : g_rot_left
      assign prev_rot = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    end
  endgenerate

  assign sample_valid = (ring != '0) && ((ring & (ring - WIDTH'(1))) == '0);
  assign legal_step   = sample_valid && prev_valid_q && (ring == prev_rot);
  assign good_inc     = good_cnt_q + GW'(1);

  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring[i]) hot_idx = IW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    idx_d        = idx_q;
    idx_valid_d  = idx_valid_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    rev_cnt_d    = rev_cnt_q;

    if (bus.clr_err_i) err_sticky_d = 1'b0;

    if (bus.en_i) begin
      prev_d       = ring;
      prev_valid_d = sample_valid;
      idx_valid_d  = sample_valid;
      if (sample_valid) idx_d = hot_idx;

      case (state_q)
        SEARCH: begin
          if (!legal_step) begin
            good_cnt_d = '0;
          end else if (good_inc == GW'(LOCK_CNT)) begin
            good_cnt_d = '0;
            state_d    = LOCKED;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        LOCKED: begin
          if (legal_step) begin
            // Stepping into index 0 closes one revolution in either direction.
            if (hot_idx == '0) rev_cnt_d = rev_cnt_q + REV_W'(1);
          end else begin
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            good_cnt_d   = '0;
            state_d      = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      good_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      rev_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      rev_cnt_q    <= rev_cnt_d;
    end
  end

  assign bus.idx_o        = idx_q;
  assign bus.idx_valid_o  = idx_valid_q;
  assign bus.locked_o     = (state_q == LOCKED);
  assign bus.err_pulse_o  = err_pulse_q;
  assign bus.err_sticky_o = err_sticky_q;
  assign bus.rev_cnt_o    = rev_cnt_q;

endmodule

// File: tb/tb_ring_counter_decoder.sv
// Directed bench for ring_counter_decoder (WIDTH=4, DIR=0, LOCK_CNT=2): an index-arithmetic
// model is checked every cycle, plus hand-computed literal expectations at key points.
module tb_ring_counter_decoder;
  localparam int W     = 4;
  localparam int LOCKN = 2;
  localparam int RW    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  ring_counter_decoder_if #(.WIDTH(W), .REV_W(RW)) bus ();

  ring_counter_decoder #(.WIDTH(W), .DIR(0), .LOCK_CNT(LOCKN), .REV_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state expressed as hot-bit positions; a legal DIR=0 step lowers the index by one mod W.
  int m_idx = 0, m_prev_idx = 0, m_good = 0, m_rev = 0;
  bit m_idx_valid = 0, m_prev_valid = 0, m_locked = 0, m_pulse = 0, m_sticky = 0;

  task automatic model_step(input bit en, input logic [W-1:0] ring, input bit clr);
    int  ones, pos;
    bit  v, legal;
    ones = 0;
    pos  = 0;
    for (int i = 0; i < W; i++) if (ring[i]) begin ones++; pos = i; end
    v = (ones == 1);
    m_pulse = 0;
    if (en) begin
      legal = v && m_prev_valid && (pos == (m_prev_idx + W - 1) % W);
      if (m_locked) begin
        if (legal) begin
          if (pos == 0) m_rev = (m_rev + 1) % (1 << RW);
        end else begin
          m_pulse  = 1;
          m_locked = 0;
          m_good   = 0;
        end
      end else if (legal) begin
        m_good++;
        if (m_good == LOCKN) begin m_locked = 1; m_good = 0; end
      end else begin
        m_good = 0;
      end
      if (v) begin m_idx = pos; m_prev_idx = pos; end
      m_idx_valid  = v;
      m_prev_valid = v;
    end
    if (m_pulse) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_idx = 0; m_prev_idx = 0; m_good = 0; m_rev = 0;
        m_idx_valid = 0; m_prev_valid = 0; m_locked = 0; m_pulse = 0; m_sticky = 0;
      end else begin
        model_step(bus.en_i, bus.ring_in_i, bus.clr_err_i);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc idx",        32'(bus.idx_o),        32'(m_idx));
        chk("cyc idx_valid",  32'(bus.idx_valid_o),  32'(m_idx_valid));
        chk("cyc locked",     32'(bus.locked_o),     32'(m_locked));
        chk("cyc err_pulse",  32'(bus.err_pulse_o),  32'(m_pulse));
        chk("cyc err_sticky", 32'(bus.err_sticky_o), 32'(m_sticky));
        chk("cyc rev_cnt",    32'(bus.rev_cnt_o),    32'(m_rev));
      end
    end
  end

  task automatic step(input bit en, input logic [W-1:0] ring, input bit clr);
    @(negedge clk);
    bus.en_i      = en;
    bus.ring_in_i = ring;
    bus.clr_err_i = clr;
    @(posedge clk);
    #1;
    $display("step en=%0d ring=%b clr=%0d -> idx=%0d v=%0d lk=%0d ep=%0d es=%0d rev=%0d",
             en, ring, clr, bus.idx_o, bus.idx_valid_o, bus.locked_o,
             bus.err_pulse_o, bus.err_sticky_o, bus.rev_cnt_o);
  endtask

  task automatic all_zero(input string nm);
    chk({nm, " idx"},        32'(bus.idx_o),        0);
    chk({nm, " idx_valid"},  32'(bus.idx_valid_o),  0);
    chk({nm, " locked"},     32'(bus.locked_o),     0);
    chk({nm, " err_pulse"},  32'(bus.err_pulse_o),  0);
    chk({nm, " err_sticky"}, 32'(bus.err_sticky_o), 0);
    chk({nm, " rev_cnt"},    32'(bus.rev_cnt_o),    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en_i      = 1'b0;
    bus.ring_in_i = '0;
    bus.clr_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    #3 rst_n = 1'b1;

    // 1: acquire
    step(1, 4'b0001, 0);
    chk("t1 idx0", 32'(bus.idx_o), 0);
    chk("t1 valid", 32'(bus.idx_valid_o), 1);
    step(1, 4'b1000, 0);
    chk("t1 idx3", 32'(bus.idx_o), 3);
    chk("t1 unlocked", 32'(bus.locked_o), 0);
    step(1, 4'b0100, 0);
    chk("t1 locked", 32'(bus.locked_o), 1);
    step(1, 4'b0010, 0);
    chk("t1 idx1", 32'(bus.idx_o), 1);
    chk("t1 rev0", 32'(bus.rev_cnt_o), 0);

    // 2: three revolutions
    for (int r = 0; r < 3; r++) begin
      step(1, 4'b0001, 0);
      step(1, 4'b1000, 0);
      step(1, 4'b0100, 0);
      step(1, 4'b0010, 0);
    end
    chk("t2 rev3", 32'(bus.rev_cnt_o), 3);
    chk("t2 sticky0", 32'(bus.err_sticky_o), 0);

    // 3: multi-hot injection
    step(1, 4'b0110, 0);
    chk("t3 pulse", 32'(bus.err_pulse_o), 1);
    chk("t3 sticky", 32'(bus.err_sticky_o), 1);
    chk("t3 unlocked", 32'(bus.locked_o), 0);
    chk("t3 invalid", 32'(bus.idx_valid_o), 0);
    chk("t3 idx hold", 32'(bus.idx_o), 1);
    step(1, 4'b0001, 0);
    chk("t3 pulse once", 32'(bus.err_pulse_o), 0);
    step(1, 4'b1000, 0);
    step(1, 4'b0100, 0);
    chk("t3 relock", 32'(bus.locked_o), 1);
    step(1, 4'b0010, 1);
    chk("t3 cleared", 32'(bus.err_sticky_o), 0);

    // 4: skipped step from 0100
    step(1, 4'b0001, 0);
    chk("t4 rev4", 32'(bus.rev_cnt_o), 4);
    step(1, 4'b1000, 0);
    step(1, 4'b0100, 0);
    step(1, 4'b0001, 0);
    chk("t4 skip err", 32'(bus.err_pulse_o), 1);
    chk("t4 skip unlock", 32'(bus.locked_o), 0);
    step(1, 4'b1000, 0);
    step(1, 4'b0100, 0);
    chk("t4 relock", 32'(bus.locked_o), 1);
    chk("t4 rev held", 32'(bus.rev_cnt_o), 4);
    step(1, 4'b0010, 1);

    // 5: enable low with garbage
    step(0, 4'b1111, 0);
    step(0, 4'b0000, 0);
    step(0, 4'b0101, 0);
    step(0, 4'b1000, 0);
    step(0, 4'b0011, 0);
    chk("t5 idx hold", 32'(bus.idx_o), 1);
    chk("t5 lock hold", 32'(bus.locked_o), 1);
    chk("t5 no err", 32'(bus.err_sticky_o), 0);
    step(1, 4'b0001, 0);
    chk("t5 resume", 32'(bus.locked_o), 1);
    chk("t5 rev5", 32'(bus.rev_cnt_o), 5);

    // 6: clear collides with error, then clear alone (with enable low)
    step(1, 4'b0011, 1);
    chk("t6 err wins", 32'(bus.err_sticky_o), 1);
    step(0, 4'b0000, 1);
    chk("t6 clr alone", 32'(bus.err_sticky_o), 0);
    step(1, 4'b0001, 0);
    step(1, 4'b1000, 0);
    step(1, 4'b0100, 0);
    chk("t6 pre-rst idx", 32'(bus.idx_o), 2);
    chk("t6 pre-rst lock", 32'(bus.locked_o), 1);
    #2 rst_n = 1'b0;
    #1;
    all_zero("async rst");
    #3 rst_n = 1'b1;
    step(1, 4'b0010, 0);
    chk("post-rst unlocked", 32'(bus.locked_o), 0);
    step(1, 4'b0001, 0);
    step(1, 4'b1000, 0);
    chk("post-rst relock", 32'(bus.locked_o), 1);
    step(1, 4'b0100, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
